// File: rtl/avalon_rsa_pkg.sv
// Shared types and constants for the RSA byte-feeder slice.
//   state_t       : reader control FSM states
//   CSR_*         : CSR slave word offsets
//   WORD_W        : DRAM word width in bits
//   BYTES_PER_WORD: bytes presented per DRAM word
package avalon_rsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] CSR_BASE  = 2'd0;
    localparam logic [1:0] CSR_COUNT = 2'd1;
    localparam logic [1:0] CSR_CTRL  = 2'd2;

    localparam int BYTES_PER_WORD = 32;
    localparam int WORD_W         = 256;

endpackage

// File: rtl/rsa_word_fifo.sv
// Synchronous first-word-fall-through FIFO of DRAM words.
//   clk, reset : clock, asynchronous active-high reset
//   i_push     : write i_data (taken when not full, or when popping the same cycle)
//   i_pop      : consume o_data (taken when not empty)
//   o_data     : head word, valid while !o_empty
//   o_full/o_empty/o_used : occupancy
module rsa_word_fifo
    import avalon_rsa_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WORD_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [WORD_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_used
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int USED_W = PTR_W + 1;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [USED_W-1:0] r_used;

    logic w_push;
    logic w_pop;

    // A pop at full frees the slot the push is about to overwrite, so both proceed.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // NOTE: storage has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_used <= r_used + USED_W'(w_push) - USED_W'(w_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_used == USED_W'(DEPTH));
    assign o_empty = (r_used == '0);
    assign o_used  = r_used;

endmodule

// File: rtl/avalon_rsa_reader.sv
// Avalon-MM read master feeding the RSA byte engine.
//   avs_s0_* : CSR slave (0 base, 1 word count, 2 ctrl: wr bit0 start / rd bit0 busy, bit1 done)
//   avm_m0_* : read master fetching count 256-bit words from base, base+32, ...
//   st_*     : byte stream, byte k of a word is readdata[8k+7:8k]; st_last on final byte
// Reads are credited against FIFO space so the word FIFO can never overflow.
module avalon_rsa_reader
    import avalon_rsa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [31:0]       avs_s0_writedata,
    output logic [31:0]       avs_s0_readdata,
    output logic              avs_s0_waitrequest,
    output logic [31:0]       avm_m0_address,
    output logic              avm_m0_read,
    input  logic              avm_m0_waitrequest,
    input  logic              avm_m0_readdatavalid,
    input  logic [WORD_W-1:0] avm_m0_readdata,
    output logic [7:0]        st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [4:0]        st_byte_idx,
    output logic              st_last
);
    localparam int USED_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OFS_W  = $clog2(BYTES_PER_WORD);
    localparam logic [USED_W:0] DEPTH_L = (USED_W+1)'(FIFO_DEPTH);
    localparam logic [4:0]      K_LAST  = 5'(BYTES_PER_WORD - 1);

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_base;
    logic [CNT_W-1:0]  r_count, r_issued, r_loaded;
    logic              r_done;
    logic [USED_W-1:0] r_outstanding;
    logic              r_read;
    logic [31:0]       r_address;
    logic [WORD_W-1:0] r_word;
    logic              r_sv;
    logic [4:0]        r_k;

    logic              w_busy, w_issue_en;
    logic              w_csr_wr_ok, w_start, w_count_zero;
    logic              w_accept, w_rvalid;
    logic [CNT_W-1:0]  w_issued_nxt;
    logic [USED_W-1:0] w_out_nxt, w_used_nxt, w_fifo_used;
    logic [USED_W:0]   w_inflight;
    logic              w_credit_ok;
    logic              w_xfer, w_word_end, w_load, w_last_xfer;
    logic [WORD_W-1:0] w_fifo_data;
    logic              w_fifo_full, w_fifo_empty;
    logic [31:0]       w_req_addr;

    rsa_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rvalid),
        .i_data  (avm_m0_readdata),
        .i_pop   (w_load),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_used  (w_fifo_used)
    );

    // CSR writes and start are honoured only in IDLE.
    assign w_csr_wr_ok  = avs_s0_write && !w_busy;
    assign w_start      = w_csr_wr_ok && (avs_s0_address == CSR_CTRL) && avs_s0_writedata[0];
    assign w_count_zero = (r_count == '0);

    assign w_accept     = r_read && !avm_m0_waitrequest;
    // Responses with nothing outstanding (e.g. stragglers after a reset) are dropped.
    assign w_rvalid     = avm_m0_readdatavalid && (r_outstanding != '0);
    assign w_issued_nxt = r_issued + CNT_W'(w_accept);
    assign w_out_nxt    = r_outstanding + USED_W'(w_accept) - USED_W'(w_rvalid);
    assign w_used_nxt   = w_fifo_used + USED_W'(w_rvalid) - USED_W'(w_load);
    // The word held by the serializer is not counted: it already left the FIFO.
    assign w_inflight   = {1'b0, w_out_nxt} + {1'b0, w_used_nxt};
    assign w_credit_ok  = (w_inflight < DEPTH_L);
    assign w_req_addr   = r_base + {{(32-CNT_W-OFS_W){1'b0}}, w_issued_nxt, {OFS_W{1'b0}}};

    assign w_xfer      = r_sv && st_ready;
    assign w_word_end  = w_xfer && (r_k == K_LAST);
    // Reload on the final byte's edge so consecutive words stream without a bubble.
    assign w_load      = !w_fifo_empty && (!r_sv || w_word_end);
    assign w_last_xfer = w_word_end && st_last;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start && !w_count_zero)                w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && (w_issued_nxt == r_count))   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_xfer)                             w_state_nxt = ST_IDLE;
            default:                                               w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy     = (r_state != ST_IDLE);
        w_issue_en = (r_state == ST_RUN);
    end

    // CSRs, issue counters and the read request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base        <= '0;
            r_count       <= '0;
            r_done        <= 1'b0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_read        <= 1'b0;
            r_address     <= '0;
        end else begin
            if (w_csr_wr_ok && (avs_s0_address == CSR_BASE))
                r_base <= {avs_s0_writedata[31:OFS_W], {OFS_W{1'b0}}};
            if (w_csr_wr_ok && (avs_s0_address == CSR_COUNT))
                r_count <= avs_s0_writedata[CNT_W-1:0];

            if (w_start) begin
                r_done   <= w_count_zero;
                r_issued <= '0;
            end else begin
                r_issued <= w_issued_nxt;
                if (w_last_xfer) r_done <= 1'b1;
            end

            r_outstanding <= w_out_nxt;

            // A stalled request keeps read and address unchanged.
            if (!(r_read && avm_m0_waitrequest)) begin
                r_read <= w_issue_en && (w_issued_nxt < r_count) && w_credit_ok;
                r_address <= w_req_addr;
            end
        end
    end

    // Byte serializer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word   <= '0;
            r_sv     <= 1'b0;
            r_k      <= '0;
            r_loaded <= '0;
        end else begin
            if (w_load) begin
                r_word <= w_fifo_data;
                r_sv   <= 1'b1;
                r_k    <= '0;
            end else if (w_xfer) begin
                r_k <= r_k + 1'b1;
                if (r_k == K_LAST) r_sv <= 1'b0;
            end

            if (w_start)     r_loaded <= '0;
            else if (w_load) r_loaded <= r_loaded + 1'b1;
        end
    end

    always_comb begin
        avs_s0_readdata = '0;
        if (avs_s0_read) begin
            case (avs_s0_address)
                CSR_BASE:  avs_s0_readdata = r_base;
                CSR_COUNT: avs_s0_readdata = 32'(r_count);
                CSR_CTRL:  avs_s0_readdata = {30'b0, r_done, w_busy};
                default:   avs_s0_readdata = '0;
            endcase
        end
    end

    assign avs_s0_waitrequest = 1'b0;
    assign avm_m0_read        = r_read;
    assign avm_m0_address     = r_address;
    assign st_valid           = r_sv;
    assign st_data            = r_word[{r_k, 3'b000} +: 8];
    assign st_byte_idx        = r_k;
    // r_loaded counts words loaded this job, so the current word is the last when it equals count.
    assign st_last            = r_sv && (r_k == K_LAST) && (r_loaded == r_count);

endmodule
